// File: rtl/mult_pkg.sv
// Shared sizing and FSM state type for the multiplier / BCD converter / display chain.
package mult_pkg;
  localparam int unsigned N      = 8;
  localparam int unsigned W      = 2 * N;
  localparam int unsigned DIGITS = (W / 3) + 1;
  localparam int unsigned NDW    = $clog2(DIGITS + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;
endpackage

// File: rtl/bin2bcd_serial_if.sv
// Request/result bundle between the multiplier (master) and the BCD converter (slave).
interface bin2bcd_serial_if #(
  parameter int unsigned W      = mult_pkg::W,
  parameter int unsigned DIGITS = mult_pkg::DIGITS,
  parameter int unsigned NDW    = mult_pkg::NDW
);
  logic                  start;
  logic [W-1:0]          bin_in;
  logic                  busy;
  logic                  done;
  logic [DIGITS*4-1:0]   bcd;
  logic [NDW-1:0]        ndigits;

  modport master (
    output start, bin_in,
    input  busy, done, bcd, ndigits
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd, ndigits
  );
endinterface

// File: rtl/bin2bcd_serial_add3.sv
// Double-dabble digit corrector: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (double-dabble), one product bit per clock,
// with a significant-digit count latched alongside the result.
module bin2bcd_serial
  import mult_pkg::*;
#(
  parameter int unsigned N      = mult_pkg::N,
  parameter int unsigned DIGITS = ((2 * N) / 3) + 1,
  parameter int unsigned NDW    = $clog2(DIGITS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  bin2bcd_serial_if.slave bus
);
  localparam int unsigned W  = 2 * N;
  localparam int unsigned BW = DIGITS * 4;
  localparam int unsigned CW = $clog2(W + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW+W-1:0]   sr_q, sr_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [NDW-1:0]    nd_q, nd_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [BW-1:0]     scr_adj;
  logic [BW+W-1:0]   shifted;
  logic [NDW-1:0]    nd_calc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr_q[W + 4*g +: 4]),
      .dout (scr_adj[4*g +: 4])
    );
  end

  // Corrected scratch and binary shift together; the scratch MSB falls off
  // (DIGITS always covers the full W-bit range, so it is never a set bit).
  always_comb begin
    shifted = {scr_adj[BW-2:0], sr_q[W-1:0], 1'b0};
    nd_calc = NDW'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (shifted[W + 4*i +: 4] != 4'd0) nd_calc = NDW'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    nd_d    = nd_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d         = '0;
          sr_d[W-1:0]  = bus.bin_in;
          cnt_d        = CW'(W);
          busy_d       = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[BW+W-1:W];
          nd_d    = nd_calc;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
      nd_q    <= NDW'(1);
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      nd_q    <= nd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd     = bcd_q;
  assign bus.ndigits = nd_q;
endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: directed table, multi-cycle corner
// sequences and randomized values against a decimal-arithmetic reference.
module tb_bin2bcd_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  bin2bcd_serial_if #(.W(16), .DIGITS(6), .NDW(3)) bus ();

  bin2bcd_serial #(.N(8), .DIGITS(6), .NDW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] bin;
    logic [23:0] bcd;
    logic [2:0]  nd;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_nd(input int unsigned v);
    int unsigned t;
    int unsigned n;
    t = v;
    n = 1;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return 3'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start with v, then waits (bounded) for done; lat counts edges after acceptance.
  task automatic conv(input logic [15:0] v, output logic [23:0] b, output logic [2:0] nd,
                      output int lat, output int bcyc);
    bus.start  = 1'b1;
    bus.bin_in = v;
    tick();
    bus.start  = 1'b0;
    bus.bin_in = 16'($urandom);
    lat  = 0;
    bcyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcyc++;
      tick();
      lat++;
    end
    b  = bus.bcd;
    nd = bus.ndigits;
  endtask

  initial begin
    logic [23:0] b;
    logic [2:0]  nd;
    int          lat;
    int          bcyc;
    int          ndone;
    logic [15:0] v;

    tbl[0]  = '{16'd0,     24'h000000, 3'd1};
    tbl[1]  = '{16'd65025, 24'h065025, 3'd5};
    tbl[2]  = '{16'hFFFF,  24'h065535, 3'd5};
    tbl[3]  = '{16'd1,     24'h000001, 3'd1};
    tbl[4]  = '{16'd9,     24'h000009, 3'd1};
    tbl[5]  = '{16'd10,    24'h000010, 3'd2};
    tbl[6]  = '{16'd99,    24'h000099, 3'd2};
    tbl[7]  = '{16'd100,   24'h000100, 3'd3};
    tbl[8]  = '{16'd1234,  24'h001234, 3'd4};
    tbl[9]  = '{16'd9999,  24'h009999, 3'd4};
    tbl[10] = '{16'd10000, 24'h010000, 3'd5};
    tbl[11] = '{16'd40960, 24'h040960, 3'd5};

    bus.start  = 1'b0;
    bus.bin_in = '0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_bcd", bus.bcd, 0);
    chk("reset_nd", bus.ndigits, 1);

    // Idle with no start: outputs hold, no spurious done.
    tick();
    tick();
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);

    for (int i = 0; i < 12; i++) begin
      conv(tbl[i].bin, b, nd, lat, bcyc);
      chk($sformatf("tbl%0d_bcd", i), b, tbl[i].bcd);
      chk($sformatf("tbl%0d_nd", i), nd, tbl[i].nd);
      chk($sformatf("tbl%0d_lat", i), lat, 16);
      chk($sformatf("tbl%0d_busycyc", i), bcyc, 16);
      chk($sformatf("tbl%0d_busy_at_done", i), bus.busy, 0);
      tick();
      chk($sformatf("tbl%0d_done_width", i), bus.done, 0);
      chk($sformatf("tbl%0d_hold", i), bus.bcd, tbl[i].bcd);
    end

    // Back-to-back: start in the done cycle is accepted; first result held meanwhile.
    conv(16'd1234, b, nd, lat, bcyc);
    chk("b2b_first_bcd", b, 24'h001234);
    bus.start  = 1'b1;
    bus.bin_in = 16'd9;
    tick();
    bus.start  = 1'b0;
    chk("b2b_accept_busy", bus.busy, 1);
    chk("b2b_held_bcd", bus.bcd, 24'h001234);
    chk("b2b_held_nd", bus.ndigits, 4);
    lat = 0;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b_lat", lat, 16);
    chk("b2b_second_bcd", bus.bcd, 24'h000009);
    chk("b2b_second_nd", bus.ndigits, 1);
    tick();

    // Start pulse during SHIFT is ignored, exactly one done.
    bus.start  = 1'b1;
    bus.bin_in = 16'd42;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    bus.start  = 1'b1;
    bus.bin_in = 16'd7777;
    tick();
    bus.start  = 1'b0;
    ndone = 0;
    lat   = 3;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) begin
        ndone++;
        chk("ign_lat", lat, 16);
        chk("ign_bcd", bus.bcd, 24'h000042);
        chk("ign_nd", bus.ndigits, 2);
      end
      tick();
      lat++;
    end
    chk("ign_done_count", ndone, 1);

    // Reset on the 5th shift edge of a 999 conversion discards it.
    bus.start  = 1'b1;
    bus.bin_in = 16'd999;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("rst_mid_busy_before", bus.busy, 1);
    reset = 1'b1;
    tick();
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_bcd", bus.bcd, 0);
    chk("rst_mid_nd", bus.ndigits, 1);
    chk("rst_mid_done", bus.done, 0);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) ndone++;
      tick();
    end
    chk("rst_no_done", ndone, 0);
    conv(16'd500, b, nd, lat, bcyc);
    chk("rst_after_bcd", b, 24'h000500);
    chk("rst_after_nd", nd, 3);
    chk("rst_after_lat", lat, 16);
    tick();

    // Randomized values against the decimal reference.
    for (int i = 0; i < 200; i++) begin
      v = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) v = v >> $urandom_range(0, 15);
      conv(v, b, nd, lat, bcyc);
      chk($sformatf("rnd%0d_bcd(%0d)", i, v), b, ref_bcd(v));
      chk($sformatf("rnd%0d_nd(%0d)", i, v), nd, ref_nd(v));
      chk($sformatf("rnd%0d_lat", i), lat, 16);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
